// File: rtl/fios_ctrl_pkg.sv
// Shared types and constants for the cascaded FIOS PE-chain sequencer.
package fios_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_AB, ST_WQ, ST_Q, ST_WM, ST_MP, ST_WF, ST_DONE
  } fios_state_t;

  localparam logic [1:0] SEL_A_A   = 2'd0;
  localparam logic [1:0] SEL_A_RES = 2'd1;
  localparam logic [1:0] SEL_A_M   = 2'd2;

  localparam logic [1:0] SEL_B_B   = 2'd0;
  localparam logic [1:0] SEL_B_P0  = 2'd1;
  localparam logic [1:0] SEL_B_P   = 2'd2;

  localparam logic [1:0] SEL_C_CI   = 2'd0;
  localparam logic [1:0] SEL_C_RESD = 2'd1;
  localparam logic [1:0] SEL_C_D1   = 2'd2;
  localparam logic [1:0] SEL_C_D2   = 2'd3;

  localparam logic [6:0] OP_NOP       = 7'b0000000;
  localparam logic [6:0] OP_M         = 7'b0000101;
  localparam logic [6:0] OP_M_C       = 7'b0110101;
  localparam logic [6:0] OP_M_PCIN_SH = 7'b1010101;

  // Wide enough for the longest phase (S <= 64).
  localparam int CNT_W = 7;

  function automatic logic [CNT_W-1:0] phase_len(fios_state_t st, int s, int lat);
    case (st)
      ST_AB, ST_MP:        phase_len = CNT_W'(s);
      ST_WQ, ST_WM, ST_WF: phase_len = CNT_W'(lat);
      default:             phase_len = CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/fios_casc_ctrl_cnt.sv
// Loadable down-counter timing each sequencer phase; tc_o flags the last cycle.
module fios_phase_cnt
  import fios_ctrl_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i)        cnt_q <= '0;
    else if (load_i)       cnt_q <= load_val_i;
    else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/fios_casc_ctrl.sv
// Per-word FIOS schedule sequencer driving the DSP PE chain controls.
// Optional abort port pair enabled by defining FIOS_CTRL_ABORT_EN.
module fios_casc_ctrl
  import fios_ctrl_pkg::*;
#(
  parameter int S     = 4,
  parameter int ABREG = 1,
  parameter int MREG  = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
`ifdef FIOS_CTRL_ABORT_EN
  input  logic                 abort_i,
  output logic                 aborted_o,
`endif
  output logic                 ready_o,
  output logic                 done_o,
  output logic [$clog2(S)-1:0] a_idx_o,
  output logic [$clog2(S)-1:0] bp_idx_o,
  output logic                 a_reg_en_o,
  output logic                 m_reg_en_o,
  output logic [1:0]           mux_A_sel_o,
  output logic [1:0]           mux_B_sel_o,
  output logic [1:0]           mux_C_sel_o,
  output logic                 CREG_en_o,
  output logic [6:0]           OPMODE_o,
  output logic                 RES_delay_en_o
);

  localparam int LAT = 1 + ABREG + MREG;
  localparam int IW  = $clog2(S);
  localparam logic [IW-1:0] LAST = IW'(S - 1);
  // Deeper DSP pipelines need the second carry delay tap on the m*p pass.
  localparam logic [1:0] C_TAIL = (LAT < 3) ? SEL_C_D1 : SEL_C_D2;

  fios_state_t      state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic             tc, load;
  logic [CNT_W-1:0] load_val;
  logic             abort;

`ifdef FIOS_CTRL_ABORT_EN
  assign abort = abort_i && (state_q != ST_IDLE);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      ST_IDLE: if (start_i && ready_o) begin
        state_d = ST_LOAD;
        i_d     = '0;
        j_d     = '0;
      end
      ST_LOAD: if (tc) state_d = ST_AB;
      ST_AB: begin
        j_d = tc ? '0 : j_q + 1'b1;
        if (tc) state_d = ST_WQ;
      end
      ST_WQ:   if (tc) state_d = ST_Q;
      ST_Q:    if (tc) state_d = ST_WM;
      ST_WM:   if (tc) state_d = ST_MP;
      ST_MP: begin
        j_d = tc ? '0 : j_q + 1'b1;
        if (tc) state_d = ST_WF;
      end
      ST_WF: if (tc) begin
        if (i_q == LAST) state_d = ST_DONE;
        else begin
          state_d = ST_LOAD;
          i_d     = i_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      i_d     = '0;
      j_d     = '0;
    end
  end

  assign load     = (state_d != state_q);
  assign load_val = phase_len(state_d, S, LAT) - CNT_W'(1);

  fios_phase_cnt u_cnt (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .load_i     (load),
    .load_val_i (load_val),
    .tc_o       (tc)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q        <= ST_IDLE;
      i_q            <= '0;
      j_q            <= '0;
      ready_o        <= 1'b1;
      done_o         <= 1'b0;
      a_idx_o        <= '0;
      bp_idx_o       <= '0;
      a_reg_en_o     <= 1'b0;
      m_reg_en_o     <= 1'b0;
      mux_A_sel_o    <= SEL_A_A;
      mux_B_sel_o    <= SEL_B_B;
      mux_C_sel_o    <= SEL_C_CI;
      CREG_en_o      <= 1'b0;
      OPMODE_o       <= OP_NOP;
      RES_delay_en_o <= 1'b0;
`ifdef FIOS_CTRL_ABORT_EN
      aborted_o      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      j_q            <= j_d;
      ready_o        <= (state_q == ST_IDLE);
      done_o         <= (state_q == ST_DONE);
      a_idx_o        <= '0;
      bp_idx_o       <= '0;
      a_reg_en_o     <= 1'b0;
      m_reg_en_o     <= 1'b0;
      mux_A_sel_o    <= SEL_A_A;
      mux_B_sel_o    <= SEL_B_B;
      mux_C_sel_o    <= SEL_C_CI;
      CREG_en_o      <= 1'b0;
      OPMODE_o       <= OP_NOP;
      RES_delay_en_o <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          a_reg_en_o <= 1'b1;
          a_idx_o    <= i_q;
        end
        ST_AB: begin
          bp_idx_o       <= j_q;
          CREG_en_o      <= 1'b1;
          RES_delay_en_o <= 1'b1;
          OPMODE_o       <= (j_q == '0) ? OP_M_C : OP_M_PCIN_SH;
        end
        ST_Q: begin
          mux_A_sel_o <= SEL_A_RES;
          mux_B_sel_o <= SEL_B_P0;
          OPMODE_o    <= OP_M;
        end
        ST_WM: m_reg_en_o <= tc;
        ST_MP: begin
          mux_A_sel_o    <= SEL_A_M;
          mux_B_sel_o    <= SEL_B_P;
          mux_C_sel_o    <= (j_q == '0) ? SEL_C_RESD : C_TAIL;
          bp_idx_o       <= j_q;
          CREG_en_o      <= 1'b1;
          RES_delay_en_o <= 1'b1;
          OPMODE_o       <= (j_q == '0) ? OP_M_C : OP_M_PCIN_SH;
        end
        default: ;
      endcase
`ifdef FIOS_CTRL_ABORT_EN
      aborted_o <= abort;
      // Abort wins over whatever the current state would have driven.
      if (abort) begin
        ready_o        <= 1'b0;
        done_o         <= 1'b0;
        a_idx_o        <= '0;
        bp_idx_o       <= '0;
        a_reg_en_o     <= 1'b0;
        m_reg_en_o     <= 1'b0;
        mux_A_sel_o    <= SEL_A_A;
        mux_B_sel_o    <= SEL_B_B;
        mux_C_sel_o    <= SEL_C_CI;
        CREG_en_o      <= 1'b0;
        OPMODE_o       <= OP_NOP;
        RES_delay_en_o <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fios_casc_ctrl.sv
// Directed bench: three sequencer configurations checked cycle by cycle against a schedule model.
module tb_fios_casc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // d0: S=2 LAT=1, d1: S=4 LAT=3, d2: S=4 LAT=2
  logic       rdy0, dn0, aen0, men0, cr0, rs0;
  logic [0:0] ai0, bi0;
  logic [1:0] A0, B0, C0;
  logic [6:0] op0;
  logic       rdy1, dn1, aen1, men1, cr1, rs1;
  logic [1:0] ai1, bi1;
  logic [1:0] A1, B1, C1;
  logic [6:0] op1;
  logic       rdy2, dn2, aen2, men2, cr2, rs2;
  logic [1:0] ai2, bi2;
  logic [1:0] A2, B2, C2;
  logic [6:0] op2;
`ifdef FIOS_CTRL_ABORT_EN
  logic abort = 1'b0;
  logic abt0, abt1, abt2;
`endif

  fios_casc_ctrl #(.S(2), .ABREG(0), .MREG(0)) d0 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
`ifdef FIOS_CTRL_ABORT_EN
    .abort_i(abort), .aborted_o(abt0),
`endif
    .ready_o(rdy0), .done_o(dn0), .a_idx_o(ai0), .bp_idx_o(bi0),
    .a_reg_en_o(aen0), .m_reg_en_o(men0), .mux_A_sel_o(A0), .mux_B_sel_o(B0),
    .mux_C_sel_o(C0), .CREG_en_o(cr0), .OPMODE_o(op0), .RES_delay_en_o(rs0));

  fios_casc_ctrl #(.S(4), .ABREG(1), .MREG(1)) d1 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
`ifdef FIOS_CTRL_ABORT_EN
    .abort_i(abort), .aborted_o(abt1),
`endif
    .ready_o(rdy1), .done_o(dn1), .a_idx_o(ai1), .bp_idx_o(bi1),
    .a_reg_en_o(aen1), .m_reg_en_o(men1), .mux_A_sel_o(A1), .mux_B_sel_o(B1),
    .mux_C_sel_o(C1), .CREG_en_o(cr1), .OPMODE_o(op1), .RES_delay_en_o(rs1));

  fios_casc_ctrl #(.S(4), .ABREG(1), .MREG(0)) d2 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
`ifdef FIOS_CTRL_ABORT_EN
    .abort_i(abort), .aborted_o(abt2),
`endif
    .ready_o(rdy2), .done_o(dn2), .a_idx_o(ai2), .bp_idx_o(bi2),
    .a_reg_en_o(aen2), .m_reg_en_o(men2), .mux_A_sel_o(A2), .mux_B_sel_o(B2),
    .mux_C_sel_o(C2), .CREG_en_o(cr2), .OPMODE_o(op2), .RES_delay_en_o(rs2));

  logic [31:0] v0, v1, v2;
  assign v0 = {1'b0, rdy0, dn0, 5'b0, ai0, 5'b0, bi0, aen0, men0, A0, B0, C0, cr0, op0, rs0};
  assign v1 = {1'b0, rdy1, dn1, 4'b0, ai1, 4'b0, bi1, aen1, men1, A1, B1, C1, cr1, op1, rs1};
  assign v2 = {1'b0, rdy2, dn2, 4'b0, ai2, 4'b0, bi2, aen2, men2, A2, B2, C2, cr2, op2, rs2};

  localparam logic [31:0] IDLE_V = 32'h4000_0000;

  // Expected outputs c cycles after the cycle in which start was sampled.
  function automatic logic [31:0] exp_out(int s, int lat, int c);
    int l, k, p, j;
    logic rdy, dn, aen, men, creg, res;
    logic [5:0] ai, bi;
    logic [1:0] a, b, cs;
    logic [6:0] op;
    l = 2*s + 3*lat + 2;
    rdy = 0; dn = 0; aen = 0; men = 0; creg = 0; res = 0;
    ai = 0; bi = 0; a = 0; b = 0; cs = 0; op = 7'b0000000;
    if (c < 2 || c > 2 + s*l) rdy = 1;
    else if (c == 2 + s*l) dn = 1;
    else begin
      k = (c - 2) / l;
      p = (c - 2) % l;
      if (p == 0) begin
        aen = 1; ai = 6'(k);
      end else if (p <= s) begin
        j = p - 1; bi = 6'(j); creg = 1; res = 1;
        op = (j == 0) ? 7'b0110101 : 7'b1010101;
      end else if (p <= s + lat) begin
      end else if (p == s + lat + 1) begin
        a = 1; b = 1; op = 7'b0000101;
      end else if (p <= s + 2*lat + 1) begin
        men = (p == s + 2*lat + 1);
      end else if (p <= 2*s + 2*lat + 1) begin
        j = p - (s + 2*lat + 2);
        a = 2; b = 2; bi = 6'(j); creg = 1; res = 1;
        cs = (j == 0) ? 2'd1 : ((lat < 3) ? 2'd2 : 2'd3);
        op = (j == 0) ? 7'b0110101 : 7'b1010101;
      end
    end
    return {1'b0, rdy, dn, ai, bi, aen, men, a, b, cs, creg, op, res};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  int d0_done_cnt, d0_done_first, d0_done_last, d1_done_cyc, d2_done_cyc;
  int d1_men_cnt, d0_aen_a, d0_aen_b;

  // Start sampled in cycle 0; checks cycles 1..n. hold keeps start high throughout.
  task automatic run_check(input int n, input int pulse_at, input bit hold);
    int l0, l1, l2;
    d0_done_cnt = 0; d0_done_first = -1; d0_done_last = -1;
    d1_done_cyc = -1; d2_done_cyc = -1; d1_men_cnt = 0; d0_aen_a = -1; d0_aen_b = -1;
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      start = hold || (c == pulse_at);
      l0 = hold ? c % (2*9 + 3)  : c;
      l1 = hold ? c % (4*19 + 3) : c;
      l2 = hold ? c % (4*16 + 3) : c;
      chk($sformatf("d0_c%0d", c), v0, exp_out(2, 1, l0));
      chk($sformatf("d1_c%0d", c), v1, exp_out(4, 3, l1));
      chk($sformatf("d2_c%0d", c), v2, exp_out(4, 2, l2));
      if (dn0) begin
        d0_done_cnt++;
        if (d0_done_first < 0) d0_done_first = c;
        d0_done_last = c;
      end
      if (dn1 && d1_done_cyc < 0) d1_done_cyc = c;
      if (dn2 && d2_done_cyc < 0) d2_done_cyc = c;
      if (men1 && c <= 78) d1_men_cnt++;
      if (aen0) begin
        if (d0_aen_a < 0) d0_aen_a = c;
        else if (d0_aen_b < 0) d0_aen_b = c;
      end
    end
  endtask

  initial begin
    step();
    step();
    chk("reset_d0", v0, IDLE_V);
    chk("reset_d1", v1, IDLE_V);
    chk("reset_d2", v2, IDLE_V);
    rst_n = 1'b1;
    step();

    // Single run with a stray start pulse mid-run.
    run_check(85, 10, 1'b0);
    chk("d0_done_cycle", 32'(d0_done_first), 32'd20);
    chk("d0_done_count", 32'(d0_done_cnt), 32'd1);
    chk("d1_done_cycle", 32'(d1_done_cyc), 32'd78);
    chk("d2_done_cycle", 32'(d2_done_cyc), 32'd66);
    chk("d1_mreg_pulses", 32'(d1_men_cnt), 32'd4);
    chk("d0_aen_first", 32'(d0_aen_a), 32'd2);
    chk("d0_aen_second", 32'(d0_aen_b), 32'd11);

    // Reset during the MP pass of word 1 on the S=4/LAT=3 instance.
    step();
    run_check(33, -1, 1'b0);
    rst_n = 1'b0;
    step();
    chk("midrst_d0", v0, IDLE_V);
    chk("midrst_d1", v1, IDLE_V);
    chk("midrst_d2", v2, IDLE_V);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_idle_d1", v1, IDLE_V);
    end
    run_check(85, -1, 1'b0);
    chk("rerun_d1_done", 32'(d1_done_cyc), 32'd78);
    chk("rerun_d0_done_count", 32'(d0_done_cnt), 32'd1);

    // Start held high: back-to-back runs.
    step();
    run_check(100, -1, 1'b1);
    chk("hold_d0_first", 32'(d0_done_first), 32'd20);
    chk("hold_d0_last", 32'(d0_done_last), 32'd83);
    chk("hold_d0_count", 32'(d0_done_cnt), 32'd4);
    start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef FIOS_CTRL_ABORT_EN
    // d0 is in WQ during cycle 4.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pulse", {29'd0, abt0, abt1, abt2}, 32'd7);
    chk("abort_outs_d0", v0, 32'd0);
    chk("abort_outs_d1", v1, 32'd0);
    step();
    chk("abort_pulse_once", {29'd0, abt0, abt1, abt2}, 32'd0);
    chk("abort_ready_d0", v0, IDLE_V);
    for (int c = 0; c < 25; c++) begin
      step();
      chk("abort_no_done_d0", v0, IDLE_V);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
